// File: rtl/uart_rx_stream.sv
// UART 8N1 receiver with a 2-flop synchroniser, mid-bit sampling and a byte FIFO
// exposed as a valid/ready stream. Define UART_RX_PARITY_EN for 8E1 framing with parity_err.
module uart_rx_stream #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx_pin,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic                          overflow,
    input  logic                          clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            framing_err_q, framing_err_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_err_q, parity_err_d;
    logic            perr_s;
`endif

    logic rxs_s, half_tick_s, bit_tick_s;
    logic push_s, ferr_s, pop_s, full_s, wr_en_s, ovf_set_s;

    assign sync_d      = {sync_q[0], uart_rx_pin};
    assign rxs_s       = sync_q[1];
    assign half_tick_s = (baud_q == HALF_LAST);
    assign bit_tick_s  = (baud_q == BAUD_LAST);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = rxs_s ? S_IDLE : S_START;
            S_START: begin
                if (half_tick_s) begin
                    state_d = rxs_s ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_tick_s && (bit_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: state_d = bit_tick_s ? S_STOP : S_PARITY;
`endif
            S_STOP: begin
                if (bit_tick_s) begin
                    state_d = rxs_s ? S_IDLE : S_BREAK;
                end else begin
                    state_d = S_STOP;
                end
            end
            // a line held low after a bad stop must not look like a new start bit
            S_BREAK: state_d = rxs_s ? S_IDLE : S_BREAK;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: baud/bit counters, shift register, push and error strobes
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push_s  = 1'b0;
        ferr_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_s    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = BW'(0);
                bit_d  = 3'd0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
            end
            S_START: baud_d = half_tick_s ? BW'(0) : baud_q + BW'(1);
            S_DATA: begin
                if (bit_tick_s) begin
                    baud_d  = BW'(0);
                    bit_d   = bit_q + 3'd1;
                    shift_d = {rxs_s, shift_q[7:1]};
                end else begin
                    baud_d  = baud_q + BW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_tick_s) begin
                    baud_d    = BW'(0);
                    par_bad_d = rxs_s ^ even_parity(shift_q);
                end else begin
                    baud_d    = baud_q + BW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_tick_s) begin
                    baud_d = BW'(0);
`ifdef UART_RX_PARITY_EN
                    push_s = rxs_s && !par_bad_q;
                    perr_s = rxs_s && par_bad_q;
`else
                    push_s = rxs_s;
`endif
                    ferr_s = !rxs_s;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_BREAK: baud_d = BW'(0);
            default: baud_d = BW'(0);
        endcase
    end

    assign pop_s     = rx_valid && rx_ready;
    assign full_s    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign wr_en_s   = push_s && (!full_s || pop_s);
    assign ovf_set_s = push_s && full_s && !pop_s;

    // FIFO pointers, registered head byte and sticky/pulsed error flags
    always_comb begin
        wr_d          = wr_q + PW'(wr_en_s);
        rd_d          = rd_q + PW'(pop_s);
        framing_err_d = ferr_s;
        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (rd_d == wr_d) begin
            rx_data_d = rx_data_q;
        end else if (rd_d == wr_q) begin
            rx_data_d = shift_q;
        end else begin
            rx_data_d = mem_q[rd_d[AW-1:0]];
        end
`ifdef UART_RX_PARITY_EN
        parity_err_d = perr_s;
`endif
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q        <= 2'b11;
            baud_q        <= BW'(0);
            bit_q         <= 3'd0;
            shift_q       <= 8'd0;
            wr_q          <= PW'(0);
            rd_q          <= PW'(0);
            rx_data_q     <= 8'd0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            sync_q        <= sync_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            rx_data_q     <= rx_data_d;
            framing_err_q <= framing_err_d;
            overflow_q    <= overflow_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= par_bad_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_q[AW-1:0]] <= shift_q;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = (wr_q != rd_q);
    assign fifo_count  = wr_q - rd_q;
    assign framing_err = framing_err_q;
    assign overflow    = overflow_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream (CLKS_PER_BIT=4, FIFO_DEPTH=16) with a queue-based
// reference model of frame arrival times and FIFO occupancy.
module tb_uart_rx_stream;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    // line falls after edge E; 2 sync flops + detect edge + half bit + 9 full bits
    localparam int OFF   = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst, pin, rx_ready, clr_err;
    logic [7:0] rx_data;
    logic       rx_valid, framing_err, overflow;
    logic [4:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_e = 0;
    int ferr_seen = 0;

    logic [7:0] mq [$];
    logic [8:0] sched [int];
    logic [7:0] m_data;
    logic       m_ovf, m_ferr;
    logic [7:0] drained [$];

    always #5 clk = ~clk;

    uart_rx_stream #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .uart_rx_pin(pin),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fifo_count(fifo_count), .framing_err(framing_err),
        .overflow(overflow), .clr_err(clr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame generator; schedules the model's expected push/framing event at E+OFF.
    task automatic send_frame(input logic [7:0] b, input int stop_low_bits, input bit sched_it);
        @(posedge clk); #1;
        pin = 1'b0;
        last_e = cyc;
        if (sched_it) sched[cyc + OFF] = {stop_low_bits != 0, b};
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 pin = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1;
        if (stop_low_bits > 0) begin
            pin = 1'b0;
            repeat (stop_low_bits * CPB) @(posedge clk);
            #1 pin = 1'b1;
        end else begin
            pin = 1'b1;
        end
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Reference model: scheduled arrivals into a bounded queue, consumer pops on ready.
    always @(posedge clk or posedge rst) begin : mdl
        int n;
        logic pop, push, fe, ovs;
        logic [7:0] b;
        if (rst) begin
            mq.delete();
            sched.delete();
            m_data <= 8'd0;
            m_ovf  <= 1'b0;
            m_ferr <= 1'b0;
        end else begin
            n = cyc + 1;
            cyc <= n;
            pop = (mq.size() != 0) && rx_ready;
            push = 1'b0;
            fe = 1'b0;
            b = 8'd0;
            if (sched.exists(n)) begin
                {fe, b} = sched[n];
                push = !fe;
                sched.delete(n);
            end
            ovs = push && (mq.size() == DEPTH) && !pop;
            if (pop) void'(mq.pop_front());
            if (push && !ovs) mq.push_back(b);
            m_ovf  <= ovs ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
            m_ferr <= fe;
            if (mq.size() != 0) m_data <= mq[0];
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("valid", rx_valid, mq.size() != 0);
        chk("count", fifo_count, mq.size());
        chk("data", rx_data, m_data);
        chk("framing_err", framing_err, m_ferr);
        chk("overflow", overflow, m_ovf);
        if (framing_err === 1'b1) ferr_seen++;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, rx_valid, 1'b0);
        chk({tag, "_count"}, fifo_count, 5'd0);
        chk({tag, "_data"}, rx_data, 8'd0);
        chk({tag, "_ferr"}, framing_err, 1'b0);
        chk({tag, "_ovf"}, overflow, 1'b0);
    endtask

    task automatic drain(input int n);
        drained.delete();
        @(posedge clk); #1 rx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("drain_valid", rx_valid, 1'b1);
            drained.push_back(rx_data);
            @(posedge clk); #1;
        end
        rx_ready = 1'b0;
    endtask

    initial begin
        int f0;
        rst = 1'b1; pin = 1'b1; rx_ready = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) chk_reset_vals("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        // single byte, exact arrival cycle
        #1 rx_ready = 1'b1;
        send_frame(8'hA5, 0, 1'b1);
        @(negedge clk) chk("a5_not_early", rx_valid, 1'b0);
        @(negedge clk);
        chk("a5_latency", cyc - last_e, 32'd41);
        chk("a5_valid", rx_valid, 1'b1);
        chk("a5_data", rx_data, 8'hA5);
        @(negedge clk) chk("a5_one_cycle", rx_valid, 1'b0);

        // one-cycle glitch on an idle line
        @(posedge clk); #1 pin = 1'b0;
        @(posedge clk); #1 pin = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("glitch_no_push", fifo_count, 5'd0);
        chk("glitch_no_ferr", ferr_seen, 32'd0);

        // stop bit held low, then a good frame
        f0 = ferr_seen;
        send_frame(8'h3C, 20, 1'b1);
        @(negedge clk);
        chk("break_ferr_once", ferr_seen - f0, 32'd1);
        chk("break_no_push", fifo_count, 5'd0);
        send_frame(8'h81, 0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("after_break_valid", rx_valid, 1'b1);
        chk("after_break_data", rx_data, 8'h81);

        // 17 bytes into a 16-deep FIFO with no consumer
        @(posedge clk); #1 rx_ready = 1'b0;
        for (int i = 0; i < 17; i++) send_frame(8'(i), 0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ovf_count", fifo_count, 5'd16);
        chk("ovf_flag", overflow, 1'b1);
        drain(16);
        for (int i = 0; i < 16; i++) chk("ovf_order", drained[i], 8'(i));
        @(negedge clk);
        chk("ovf_sticky", overflow, 1'b1);
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk) chk("ovf_cleared", overflow, 1'b0);

        // full FIFO: push coincides with a pop
        for (int i = 0; i < 16; i++) send_frame(8'(32 + i), 0, 1'b1);
        fork
            send_frame(8'h55, 0, 1'b1);
            begin
                @(posedge clk);
                repeat (OFF - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        @(negedge clk);
        chk("fullpop_count", fifo_count, 5'd16);
        chk("fullpop_ovf", overflow, 1'b0);
        drain(16);
        for (int i = 0; i < 15; i++) chk("fullpop_order", drained[i], 8'(33 + i));
        chk("fullpop_last", drained[15], 8'h55);

        // reset during DATA of 0xFF with a byte already buffered
        send_frame(8'h77, 0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_data", rx_data, 8'h77);
        @(posedge clk); #1 pin = 1'b0;
        repeat (CPB) @(posedge clk);
        #1 pin = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk) chk_reset_vals("midframe_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk) chk("no_partial_push", fifo_count, 5'd0);
        @(posedge clk); #1 rx_ready = 1'b1;
        send_frame(8'h12, 0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_latency", cyc - last_e, 32'd41);
        chk("post_rst_valid", rx_valid, 1'b1);
        chk("post_rst_data", rx_data, 8'h12);
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
